// File: rtl/fos_out_decim_pkg.sv
// fos_out_decim_pkg: shared constants and helpers for the IIR output decimator.
package fos_out_decim_pkg;
    localparam int DEC_MIN = 1;
    localparam int DEC_MAX = 16;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic longint sat_hi(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction
endpackage

// File: rtl/fos_sync_fifo.sv
// fos_sync_fifo: first-word-fall-through FIFO; a push at full is accepted only
// when a pop frees a slot on the same edge.
module fos_sync_fifo
    import fos_out_decim_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [ptr_w(DEPTH):0]    level
);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp, r_rp;
    logic [PW:0]      r_level;
    logic             w_push, w_pop;

    assign full    = r_level == (PW+1)'(DEPTH);
    assign empty   = r_level == '0;
    assign level   = r_level;
    assign w_pop   = pop && !empty;
    assign w_push  = push && (!full || w_pop);
    assign rd_data = empty ? '0 : r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            r_level <= r_level + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/fos_out_decim.sv
// fos_out_decim: drops the post-reset filter transient, boxcar-sums R samples,
// shifts and saturates each block sum, and queues results toward the sink.
module fos_out_decim
    import fos_out_decim_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int ACC_W      = 40,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int WARMUP     = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    input  logic signed [IN_W-1:0]         y_in,
    input  logic [4:0]                     dec_ratio,
    output logic signed [OUT_W-1:0]        out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           ovf,
    output logic                           sat,
    input  logic                           clr_flags
);
    localparam int WW = $clog2(WARMUP + 2);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(OUT_W));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(OUT_W));

    logic [WW-1:0]           r_warm;
    logic [4:0]              r_cnt, r_r;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf, r_sat;

    logic                    w_warm, w_take, w_done, w_hi, w_lo, w_pop, w_full, w_empty;
    logic [4:0]              w_dr, w_r;
    logic signed [ACC_W-1:0] w_sum, w_shr;
    logic [OUT_W-1:0]        w_res, w_head;

    assign w_warm = r_warm < WW'(WARMUP);
    assign w_take = in_valid && !w_warm;
    assign w_dr   = (dec_ratio == '0) ? 5'(DEC_MIN) :
                    (dec_ratio > 5'(DEC_MAX)) ? 5'(DEC_MAX) : dec_ratio;
    // Block length is frozen at the first sample so mid-block changes wait.
    assign w_r    = (r_cnt == '0) ? w_dr : r_r;
    assign w_done = w_take && (r_cnt + 5'd1 == w_r);
    assign w_sum  = r_acc + {{(ACC_W-IN_W){y_in[IN_W-1]}}, y_in};
    assign w_shr  = w_sum >>> SHIFT;
    assign w_hi   = w_shr > SAT_HI;
    assign w_lo   = w_shr < SAT_LO;
    assign w_res  = w_hi ? SAT_HI[OUT_W-1:0] : w_lo ? SAT_LO[OUT_W-1:0] : w_shr[OUT_W-1:0];
    assign w_pop  = !w_empty && out_ready;

    assign out_valid = !w_empty;
    assign out_data  = w_head;
    assign ovf       = r_ovf;
    assign sat       = r_sat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_warm <= '0;
            r_cnt  <= '0;
            r_r    <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            if (in_valid && w_warm) r_warm <= r_warm + WW'(1);
            if (w_take) begin
                if (r_cnt == '0) r_r <= w_dr;
                r_acc <= w_done ? '0 : w_sum;
                r_cnt <= w_done ? '0 : r_cnt + 5'd1;
            end
            r_ovf <= (w_done && w_full && !w_pop) || (r_ovf && !clr_flags);
            r_sat <= (w_done && (w_hi || w_lo)) || (r_sat && !clr_flags);
        end
    end

    fos_sync_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_done),
        .wr_data (w_res),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );
endmodule

// File: tb/tb_fos_out_decim.sv
// tb_fos_out_decim: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of warmup, block sums, saturation and the FIFO.
module tb_fos_out_decim;
    localparam int IN_W = 32, OUT_W = 16, ACC_W = 40, SHIFT = 2, DEPTH = 8, WARMUP = 2;

    logic                     clk = 1'b0, reset_n = 1'b0;
    logic                     in_valid = 1'b0, out_ready = 1'b0, clr_flags = 1'b0;
    logic signed [IN_W-1:0]   y_in = '0;
    logic [4:0]               dec_ratio = 5'd1;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid, ovf, sat;
    logic [3:0]               fifo_level;

    int n_tests = 0, n_fail = 0;

    longint q[$];
    longint blk[$];
    int     warm = 0, r_lat = 1;
    bit     m_ovf = 0, m_sat = 0;

    always #5 clk = ~clk;

    fos_out_decim #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .SHIFT(SHIFT),
                    .FIFO_DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .y_in(y_in),
        .dec_ratio(dec_ratio), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level), .ovf(ovf), .sat(sat),
        .clr_flags(clr_flags));

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, "_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({ph, "_level"}, 64'(fifo_level), 64'(q.size()));
        chk({ph, "_data"}, 64'($signed(out_data)), q.size() > 0 ? q[0] : 64'sd0);
        chk({ph, "_ovf"}, 64'(ovf), 64'(m_ovf));
        chk({ph, "_sat"}, 64'(sat), 64'(m_sat));
    endtask

    task automatic model_reset();
        q.delete(); blk.delete();
        warm = 0; m_ovf = 0; m_sat = 0;
    endtask

    task automatic model_step();
        bit pop, push, clip, drop;
        longint sum, res;
        pop = q.size() > 0 && out_ready;
        push = 0; clip = 0; res = 0;
        if (in_valid) begin
            if (warm < WARMUP) warm++;
            else begin
                if (blk.size() == 0)
                    r_lat = dec_ratio == 0 ? 1 : (dec_ratio > 16 ? 16 : int'(dec_ratio));
                blk.push_back(longint'(y_in));
                if (blk.size() == r_lat) begin
                    sum = 0;
                    foreach (blk[i]) sum += blk[i];
                    res = sum >>> SHIFT;
                    if (res > 32767) begin res = 32767; clip = 1; end
                    if (res < -32768) begin res = -32768; clip = 1; end
                    push = 1;
                    blk.delete();
                end
            end
        end
        drop = push && q.size() == DEPTH && !pop;
        if (pop) void'(q.pop_front());
        if (push && !drop) q.push_back(res);
        m_ovf = drop ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
        m_sat = clip ? 1'b1 : (clr_flags ? 1'b0 : m_sat);
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        model_step();
        #1;
        check_all(ph);
    endtask

    task automatic drive(input logic v, input int y, input int d, input logic r, input logic c);
        in_valid = v; y_in = y; dec_ratio = 5'(d); out_ready = r; clr_flags = c;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int first;
        // 1: warmup and steady R=4 stream
        do_reset();
        first = -1;
        for (int i = 1; i <= 14; i++) begin
            drive(1, 100, 4, 1, 0);
            cycle("t1");
            if (out_valid && first < 0) first = i;
            if (out_valid) chk("t1_value", 64'($signed(out_data)), 64'sd100);
        end
        chk("t1_latency", 64'(first), 64'sd6);

        // 2: saturation both ways, then clear
        do_reset();
        drive(1, 7, 2, 0, 0); cycle("t2w"); cycle("t2w");
        drive(1, 200000, 2, 0, 0); cycle("t2"); cycle("t2");
        drive(1, -200000, 2, 0, 0); cycle("t2"); cycle("t2");
        chk("t2_hi", 64'($signed(out_data)), 64'sd32767);
        chk("t2_sat", 64'(sat), 64'sd1);
        drive(0, 0, 2, 1, 0); cycle("t2_pop");
        chk("t2_lo", 64'($signed(out_data)), -64'sd32768);
        drive(0, 0, 2, 0, 1); cycle("t2_clr");
        chk("t2_sat_clr", 64'(sat), 64'sd0);

        // 3: overflow under backpressure, then in-order drain
        do_reset();
        drive(1, 0, 1, 0, 0); cycle("t3w"); cycle("t3w");
        for (int k = 1; k <= 9; k++) begin drive(1, 4 * k, 1, 0, 0); cycle("t3"); end
        chk("t3_level", 64'(fifo_level), 64'sd8);
        chk("t3_ovf", 64'(ovf), 64'sd1);
        for (int k = 1; k <= 8; k++) begin
            chk("t3_order", 64'($signed(out_data)), 64'(k));
            drive(0, 0, 1, 1, 0); cycle("t3d");
        end
        chk("t3_empty", 64'(out_valid), 64'sd0);

        // 4: full FIFO with simultaneous push and pop
        drive(0, 0, 1, 0, 1); cycle("t4c");
        for (int k = 1; k <= 8; k++) begin drive(1, 4 * k, 1, 0, 0); cycle("t4f"); end
        for (int k = 9; k <= 12; k++) begin
            drive(1, 4 * k, 1, 1, 0); cycle("t4");
            chk("t4_level", 64'(fifo_level), 64'sd8);
            chk("t4_head", 64'($signed(out_data)), 64'(k - 7));
        end
        chk("t4_ovf", 64'(ovf), 64'sd0);

        // 5: dec_ratio change mid-block and R=0
        do_reset();
        drive(1, 0, 4, 0, 0); cycle("t5w"); cycle("t5w");
        drive(1, 4, 4, 0, 0); cycle("t5"); cycle("t5");
        drive(1, 4, 2, 0, 0); cycle("t5"); cycle("t5");
        chk("t5_r4", 64'($signed(out_data)), 64'sd4);
        cycle("t5"); cycle("t5");
        chk("t5_r2_level", 64'(fifo_level), 64'sd2);
        drive(1, 8, 0, 0, 0); cycle("t5z");
        chk("t5_r0_level", 64'(fifo_level), 64'sd3);

        // 6: reset mid-block with level 3
        drive(1, 40, 4, 0, 0); cycle("t6"); cycle("t6");
        chk("t6_level3", 64'(fifo_level), 64'sd3);
        do_reset();
        chk("t6_after", 64'(out_valid), 64'sd0);
        drive(1, 40, 1, 1, 0); cycle("t6w"); cycle("t6w");
        chk("t6_warm", 64'(out_valid), 64'sd0);
        cycle("t6r");
        chk("t6_first", 64'($signed(out_data)), 64'sd10);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int y;
            y = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
            drive($urandom_range(0, 3) != 0, y, int'($urandom_range(0, 20)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            cycle("rnd");
            if (i == 1500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
